// File: rtl/fir_eq_pkg.sv
// Shared definitions for the audio-equalizer FIR and its coefficient loader.
// Tap count and coefficient width live here so both sides agree on them.
package fir_eq_pkg;

    localparam int N_TAPS_DEF  = 32;
    localparam int WD_COEF_DEF = 18;

    // Loader control states:
    //   IDLE  - waiting for the first beat of a set
    //   LOAD  - collecting the remaining beats
    //   ARMED - full set written, waiting for a sample strobe
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ARMED = 2'd2
    } coef_ld_state_t;

endpackage

// File: rtl/fir_coef_bank_loader.sv
// Coefficient bank loader for the pipelined equalizer FIR.
// It streams a host coefficient set into the shadow bank and swaps the
// active and shadow banks only on a sample strobe. The FIR therefore never
// filters with a mix of old and new coefficients.
//
// Handshake: a beat transfers on a rising clk edge where cfg_valid and
// cfg_ready are both 1. cfg_ready is registered and does not depend on
// cfg_valid. The host holds cfg_data/cfg_last stable while cfg_valid is
// high and the beat has not yet transferred.
module fir_coef_bank_loader
    import fir_eq_pkg::*;
#(
    parameter int N_TAPS  = N_TAPS_DEF,
    parameter int WD_COEF = WD_COEF_DEF,
    parameter int WD_ADDR = $clog2(N_TAPS)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sample_en,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [WD_COEF-1:0]   cfg_data,
    input  logic                 cfg_last,
    output logic                 coef_we,
    output logic [WD_ADDR:0]     coef_addr,
    output logic [WD_COEF-1:0]   coef_data,
    output logic                 active_bank,
    output logic                 swap_pending,
    output logic                 load_err,
    output coef_ld_state_t       state_dbg
);

    localparam logic [WD_ADDR-1:0] LAST_TAP = WD_ADDR'(N_TAPS - 1);

    coef_ld_state_t       state_q, state_d;
    logic [WD_ADDR-1:0]   cnt_q, cnt_d;
    logic                 ready_q, ready_d;
    logic                 bank_q, bank_d;
    logic                 swap_q, swap_d;
    logic                 err_q, err_d;
    logic                 we_q;
    logic [WD_ADDR:0]     addr_q;
    logic [WD_COEF-1:0]   data_q;
    logic                 accept;

    // The host is stalled while ARMED, so ready_q gates every transfer.
    assign accept = cfg_valid && ready_q;

    // Next-state logic for the FSM, tap counter, bank select and flags.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bank_d  = bank_q;
        swap_d  = swap_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    err_d = 1'b0;
                    if (cfg_last) begin
                        // A one-beat set can never be complete.
                        err_d = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d   = WD_ADDR'(1);
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    if (cnt_q == LAST_TAP) begin
                        cnt_d   = '0;
                        if (cfg_last) begin
                            state_d = ARMED;
                            swap_d  = 1'b1;
                        end else begin
                            // Missing last: the beat is still written.
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end else if (cfg_last) begin
                        // Early last: drop the partial set.
                        err_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ARMED: begin
                // A strobe on the cycle of the final beat is ignored,
                // because the FSM is still in LOAD on that cycle.
                if (sample_en) begin
                    bank_d  = ~bank_q;
                    swap_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        ready_d = (state_d != ARMED);
    end

    // Control state registers. Reset asserts asynchronously; release is synchronous upstream.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            bank_q  <= 1'b0;
            swap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            bank_q  <= bank_d;
            swap_q  <= swap_d;
            err_q   <= err_d;
        end
    end

    // Registered RAM write port. It targets the bank the FIR is not reading,
    // so the final write lands before any toggle of active_bank.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            we_q <= accept;
            if (accept) begin
                addr_q <= {~bank_q, cnt_q};
                data_q <= cfg_data;
            end
        end
    end

    assign cfg_ready    = ready_q;
    assign coef_we      = we_q;
    assign coef_addr    = addr_q;
    assign coef_data    = data_q;
    assign active_bank  = bank_q;
    assign swap_pending = swap_q;
    assign load_err     = err_q;
    assign state_dbg    = state_q;

endmodule
